core_decode: RTL

//  RV32I(+F subset) decode stage feeding the ALU. Accepts 32-bit instruction words over a

---
 rtl/core_decode_if.sv | 33 +++
 rtl/core_decode.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_decode_if.sv
// Decode-stage bundle: fetch-side request, flush, and decoded result toward the ALU.
// Latency: none; signal bundle only.
// Backpressure: in_ready/out_ready carry the valid-ready handshakes on each side.
interface core_decode_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [40:0]     op;
  logic [4:0]      rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [31:0]     imm;
  logic [PC_W-1:0] out_pc;
  logic            illegal;

  // Fetch and consumer side.
  modport master (
    output flush, in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, op, rd, rs1_addr, rs2_addr, imm, out_pc, illegal
  );

  // Decoder side.
  modport slave (
    input  flush, in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, op, rd, rs1_addr, rs2_addr, imm, out_pc, illegal
  );
endinterface

// File: rtl/core_decode.sv
// RV32I (+ optional F subset, enabled by CORE_DECODE_FP_EN) decoder: one-hot op, reg indices, imm, PC.
// Latency: 1 cycle instruction-in to decoded-out when the output is not stalled.
// Backpressure: 2-entry skid (output + skid reg); in_ready is registered and drops only when skid is full.
module core_decode #(
  parameter int PC_W        = 32,
  parameter bit SHAMT_CHECK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  core_decode_if.slave  bus
);

  localparam int OP_ADDI    = 0;
  localparam int OP_SLTI    = 1;
  localparam int OP_SLTIU   = 2;
  localparam int OP_XORI    = 3;
  localparam int OP_ORI     = 4;
  localparam int OP_ANDI    = 5;
  localparam int OP_SLLI    = 6;
  localparam int OP_SRLI    = 7;
  localparam int OP_SRAI    = 8;
  localparam int OP_ADD     = 9;
  localparam int OP_SUB     = 10;
  localparam int OP_SLL     = 11;
  localparam int OP_SLT     = 12;
  localparam int OP_SLTU    = 13;
  localparam int OP_XOR     = 14;
  localparam int OP_SRL     = 15;
  localparam int OP_SRA     = 16;
  localparam int OP_OR      = 17;
  localparam int OP_AND     = 18;
  localparam int OP_BEQ     = 19;
  localparam int OP_BNE     = 20;
  localparam int OP_BLT     = 21;
  localparam int OP_BGE     = 22;
  localparam int OP_BLTU    = 23;
  localparam int OP_BGEU    = 24;
  localparam int OP_LB      = 25;
  localparam int OP_LH      = 26;
  localparam int OP_LW      = 27;
  localparam int OP_LBU     = 28;
  localparam int OP_LHU     = 29;
  localparam int OP_SB      = 30;
  localparam int OP_SH      = 31;
  localparam int OP_SW      = 32;
`ifdef CORE_DECODE_FP_EN
  localparam int OP_FLW     = 33;
  localparam int OP_FSW     = 34;
  localparam int OP_FMVSX   = 35;
  localparam int OP_FSGNJXS = 36;
`endif
  localparam int OP_LUI     = 37;
  localparam int OP_AUIPC   = 38;
  localparam int OP_JAL     = 39;
  localparam int OP_JALR    = 40;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOADFP = 7'b0000111;
  localparam logic [6:0] OPC_STOREFP= 7'b0100111;
  localparam logic [6:0] OPC_OPFP   = 7'b1010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [40:0]     op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } entry_t;

  logic [31:0] i;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [40:0] op_d;
  logic [31:0] imm_d;
  entry_t      dec;

  entry_t out_q, skid_q;
  logic   out_valid_q, skid_valid_q, in_ready_q;
  logic   accept, advance;

  assign i   = bus.instr;
  assign opc = i[6:0];
  assign f3  = i[14:12];
  assign f7  = i[31:25];

  assign imm_i = {{20{i[31]}}, i[31:20]};
  assign imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
  assign imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u = {i[31:12], 12'b0};
  assign imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};

  // One-hot op decode from opcode/funct3/funct7; anything unmatched leaves op_d zero.
  always_comb begin
    op_d = '0;
    case (opc)
      OPC_OPIMM: begin
        case (f3)
          3'b000: op_d[OP_ADDI]  = 1'b1;
          3'b010: op_d[OP_SLTI]  = 1'b1;
          3'b011: op_d[OP_SLTIU] = 1'b1;
          3'b100: op_d[OP_XORI]  = 1'b1;
          3'b110: op_d[OP_ORI]   = 1'b1;
          3'b111: op_d[OP_ANDI]  = 1'b1;
          3'b001: if (!SHAMT_CHECK || f7 == 7'b0000000) op_d[OP_SLLI] = 1'b1;
          3'b101: begin
            if (f7 == 7'b0000000)      op_d[OP_SRLI] = 1'b1;
            else if (f7 == 7'b0100000) op_d[OP_SRAI] = 1'b1;
            else if (!SHAMT_CHECK) begin
              // Lenient mode: bit 30 alone picks arithmetic vs logical.
              if (i[30]) op_d[OP_SRAI] = 1'b1;
              else       op_d[OP_SRLI] = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: op_d[OP_ADD]  = 1'b1;
            3'b001: op_d[OP_SLL]  = 1'b1;
            3'b010: op_d[OP_SLT]  = 1'b1;
            3'b011: op_d[OP_SLTU] = 1'b1;
            3'b100: op_d[OP_XOR]  = 1'b1;
            3'b101: op_d[OP_SRL]  = 1'b1;
            3'b110: op_d[OP_OR]   = 1'b1;
            3'b111: op_d[OP_AND]  = 1'b1;
            default: ;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) op_d[OP_SUB] = 1'b1;
          if (f3 == 3'b101) op_d[OP_SRA] = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000: op_d[OP_BEQ]  = 1'b1;
          3'b001: op_d[OP_BNE]  = 1'b1;
          3'b100: op_d[OP_BLT]  = 1'b1;
          3'b101: op_d[OP_BGE]  = 1'b1;
          3'b110: op_d[OP_BLTU] = 1'b1;
          3'b111: op_d[OP_BGEU] = 1'b1;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        case (f3)
          3'b000: op_d[OP_LB]  = 1'b1;
          3'b001: op_d[OP_LH]  = 1'b1;
          3'b010: op_d[OP_LW]  = 1'b1;
          3'b100: op_d[OP_LBU] = 1'b1;
          3'b101: op_d[OP_LHU] = 1'b1;
          default: ;
        endcase
      end
      OPC_STORE: begin
        case (f3)
          3'b000: op_d[OP_SB] = 1'b1;
          3'b001: op_d[OP_SH] = 1'b1;
          3'b010: op_d[OP_SW] = 1'b1;
          default: ;
        endcase
      end
`ifdef CORE_DECODE_FP_EN
      OPC_LOADFP:  if (f3 == 3'b010) op_d[OP_FLW] = 1'b1;
      OPC_STOREFP: if (f3 == 3'b010) op_d[OP_FSW] = 1'b1;
      OPC_OPFP: begin
        if (f7 == 7'b1111000 && i[24:20] == 5'd0 && f3 == 3'b000) op_d[OP_FMVSX]   = 1'b1;
        if (f7 == 7'b0010000 && f3 == 3'b010)                     op_d[OP_FSGNJXS] = 1'b1;
      end
`endif
      OPC_LUI:   op_d[OP_LUI]   = 1'b1;
      OPC_AUIPC: op_d[OP_AUIPC] = 1'b1;
      OPC_JAL:   op_d[OP_JAL]   = 1'b1;
      OPC_JALR:  if (f3 == 3'b000) op_d[OP_JALR] = 1'b1;
      default: ;
    endcase
  end

  // Immediate format follows the opcode alone, so illegal entries still carry the extracted value.
  always_comb begin
    imm_d = '0;
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_LOADFP, OPC_JALR: imm_d = imm_i;
      OPC_STORE, OPC_STOREFP:                    imm_d = imm_s;
      OPC_BRANCH:                                imm_d = imm_b;
      OPC_LUI, OPC_AUIPC:                        imm_d = imm_u;
      OPC_JAL:                                   imm_d = imm_j;
      default:                                   imm_d = '0;
    endcase
  end

  // Assemble the decoded entry presented to the buffer.
  always_comb begin
    dec         = '0;
    dec.op      = op_d;
    dec.rd      = i[11:7];
    dec.rs1     = i[19:15];
    dec.rs2     = i[24:20];
    dec.imm     = imm_d;
    dec.pc      = bus.in_pc;
    dec.illegal = (op_d == '0);
  end

  assign accept  = bus.in_valid & in_ready_q;
  assign advance = ~out_valid_q | bus.out_ready;

  // Handshake state: output/skid occupancy and the registered ready; flush beats accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (advance) begin
      // Skid drains first to keep order; accept cannot coincide since ready was low.
      out_valid_q  <= skid_valid_q | accept;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end else begin
      in_ready_q   <= ~skid_valid_q;
    end
  end

  // Payload registers: output holds while stalled, skid captures an accept during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!bus.flush) begin
      if (advance) begin
        if (skid_valid_q) out_q <= skid_q;
        else if (accept)  out_q <= dec;
      end else if (accept) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op        = out_q.op;
  assign bus.rd        = out_q.rd;
  assign bus.rs1_addr  = out_q.rs1;
  assign bus.rs2_addr  = out_q.rs2;
  assign bus.imm       = out_q.imm;
  assign bus.out_pc    = out_q.pc;
  assign bus.illegal   = out_q.illegal;

endmodule
